atto_bus_arbiter: RTL and testbench
===================================

Name: atto_bus_arbiter

Overview:
- Shares the single external memory bus (16-bit address, 8-bit data) between two masters.
- Master 0 is the CPU core's bus port; master 1 is a DMA/peripheral engine.
- Sequences each access as a fixed-length bus cycle: grant, drive, wait states, capture, acknowledge.
- Round-robin fairness, plus an optional lock for back-to-back ownership.

Parameters:
WAIT_CYCLES, 1, extra memory wait states per access (legal 0..15).

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
m0_req  in  1  master 0 access request
m0_dir  in  1  master 0 direction: 1=read, 0=write
m0_lock  in  1  master 0 requests ownership of the next arbitration
m0_addr  in  16  master 0 address
m0_wdata  in  8  master 0 write data
m1_req  in  1  master 1 access request
m1_dir  in  1  master 1 direction: 1=read, 0=write
m1_lock  in  1  master 1 lock
m1_addr  in  16  master 1 address
m1_wdata  in  8  master 1 write data
m0_grant  out  1  master 0 owns bus (GRANT..DONE)
m1_grant  out  1  master 1 owns bus
m0_ack  out  1  one-cycle completion pulse, master 0
m1_ack  out  1  one-cycle completion pulse, master 1
rdata  out  8  read data, valid in the ack cycle
mem_addr  out  16  memory address bus
mem_dir  out  1  memory direction: 1=read, 0=write
mem_wdata  out  8  memory write data
mem_drive  out  1  enable for the data-bus output driver
mem_rdata  in  8  memory read data

Behaviour:
- Reset (async, immediate): state=IDLE, last=1 (master 0 wins first tie), wait counter=0, lock_owner=none.
  - Outputs at reset: grants 0, acks 0, rdata 0, mem_addr 0, mem_dir 1, mem_wdata 0, mem_drive 0.
  - Reset mid-access aborts the access; no ack is issued.
- FSM states: IDLE, GRANT, ACCESS, DONE.
- IDLE: sample reqs.
  - None -> stay.
  - One -> that master.
  - Both -> the master not equal to last, unless lock_owner holds a requesting master, which then wins.
  - Latch sel, addr, dir, wdata into internal registers; assert sel grant; go GRANT.
- GRANT (1 cycle): mem_addr, mem_dir, mem_wdata driven from latched values; mem_drive=~dir; counter=WAIT_CYCLES; go ACCESS.
- ACCESS: bus held stable.
  - Counter>0 -> decrement, stay.
  - Counter==0 -> capture mem_rdata into rdata if read; mem_drive=0; go DONE.
- DONE (1 cycle): sel ack=1; grant remains 1; last=sel.
  - lock_owner=sel if sel lock was 1 in this cycle, else none.
  - Go IDLE; grant drops on exit.
- Latency: request seen in IDLE at edge N -> grant at N+1 -> ack high during cycle N+3+WAIT_CYCLES.
  - Minimum is 4 cycles request-to-ack with WAIT_CYCLES=0.
  - Back-to-back accesses by one master: one IDLE cycle between acks.
- Masters hold req/addr/dir/wdata stable until ack. The arbiter uses latched copies, so later changes are ignored.
- req deasserted after grant: the access still completes and the ack is still issued.
- rdata holds the last read value until the next read capture. Writes do not change rdata.
- After DONE, mem_addr/mem_dir/mem_wdata hold their last values. mem_dir returns to 1 and mem_drive stays 0 in IDLE.
- Lock applies to the next arbitration only. If the lock owner is not requesting in IDLE, lock_owner clears and normal round-robin applies.
- Never both grants high. Never both acks high. mem_drive never high in a read access.

Test Plan:
- Reset, then m0 read of 0x1234, WAIT_CYCLES=1, mem_rdata=0xA5 -> mem_addr=0x1234, mem_dir=1; m0_ack pulses 5 cycles after req; rdata=0xA5; mem_drive stays 0.
- m1 write 0x5A to 0x8001 -> mem_dir=0, mem_wdata=0x5A, mem_drive=1 from GRANT through the last ACCESS cycle; m1_ack pulses once; rdata unchanged.
- m0_req and m1_req held high continuously -> grant order m0, m1, m0, m1; each ack 1 cycle; no overlap of grants.
- Both requesting, m1 asserts m1_lock in its DONE cycle -> next grant goes to m1 again. Without lock the following grant returns to m0.
- Assert reset during ACCESS of an m0 write -> all outputs return to reset values immediately, no m0_ack. After release, pending m0_req is regranted from GRANT.
- m0 changes addr to 0xFFFF and drops req after grant -> mem_addr stays at the original value; ack still issued.

Source files
------------

// File: rtl/atto_bus_arbiter.sv
// atto_bus_arbiter: two-master arbiter for the single external memory bus.
// Each access runs a fixed sequence: grant, drive, wait states, capture,
// acknowledge. Ties are broken round-robin, and a master can claim the
// next arbitration with its lock input.
module atto_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_dir,
    input  logic        m0_lock,
    input  logic [15:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    input  logic        m1_req,
    input  logic        m1_dir,
    input  logic        m1_lock,
    input  logic [15:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    output logic        m0_grant,
    output logic        m1_grant,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [7:0]  rdata,
    output logic [15:0] mem_addr,
    output logic        mem_dir,
    output logic [7:0]  mem_wdata,
    output logic        mem_drive,
    input  logic [7:0]  mem_rdata
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              dir;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              lock_valid_q, lock_valid_d;
    logic              lock_owner_q, lock_owner_d;
    logic              sel_q, sel_d;
    logic              dir_q, dir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              m0_grant_d, m1_grant_d;
    logic              m0_ack_d, m1_ack_d;
    logic [DATA_W-1:0] rdata_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              mem_dir_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              mem_drive_d;

    bus_req_t          req0, req1, win;
    logic              win_sel;

    assign req0 = '{addr: m0_addr, dir: m0_dir, wdata: m0_wdata};
    assign req1 = '{addr: m1_addr, dir: m1_dir, wdata: m1_wdata};

    // Arbitration, access sequencing and next values of every registered output
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        sel_d        = sel_q;
        dir_d        = dir_q;
        cnt_d        = cnt_q;
        m0_grant_d   = m0_grant;
        m1_grant_d   = m1_grant;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        rdata_d      = rdata;
        mem_addr_d   = mem_addr;
        mem_dir_d    = mem_dir;
        mem_wdata_d  = mem_wdata;
        mem_drive_d  = mem_drive;

        // On a tie the lock owner (necessarily requesting) wins, else the master not served last
        if (m0_req && m1_req) begin
            win_sel = lock_valid_q ? lock_owner_q : ~last_q;
        end else begin
            win_sel = m1_req;
        end
        win = win_sel ? req1 : req0;

        case (state_q)
            ST_IDLE: begin
                mem_dir_d   = 1'b1;
                mem_drive_d = 1'b0;
                // A lock only covers this arbitration: it is either used now or its owner is idle
                lock_valid_d = 1'b0;
                if (m0_req || m1_req) begin
                    state_d     = ST_GRANT;
                    sel_d       = win_sel;
                    dir_d       = win.dir;
                    mem_addr_d  = win.addr;
                    mem_dir_d   = win.dir;
                    mem_wdata_d = win.wdata;
                    mem_drive_d = ~win.dir;
                    m0_grant_d  = ~win_sel;
                    m1_grant_d  = win_sel;
                end
            end
            ST_GRANT: begin
                cnt_d   = CNT_W'(WAIT_CYCLES);
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (dir_q) begin
                        rdata_d = mem_rdata;
                    end
                    mem_drive_d = 1'b0;
                    m0_ack_d    = ~sel_q;
                    m1_ack_d    = sel_q;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                last_d       = sel_q;
                lock_owner_d = sel_q;
                lock_valid_d = sel_q ? m1_lock : m0_lock;
                m0_grant_d   = 1'b0;
                m1_grant_d   = 1'b0;
                mem_dir_d    = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
            sel_q        <= 1'b0;
            dir_q        <= 1'b1;
            cnt_q        <= '0;
            m0_grant     <= 1'b0;
            m1_grant     <= 1'b0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            rdata        <= '0;
            mem_addr     <= '0;
            mem_dir      <= 1'b1;
            mem_wdata    <= '0;
            mem_drive    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            sel_q        <= sel_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            m0_grant     <= m0_grant_d;
            m1_grant     <= m1_grant_d;
            m0_ack       <= m0_ack_d;
            m1_ack       <= m1_ack_d;
            rdata        <= rdata_d;
            mem_addr     <= mem_addr_d;
            mem_dir      <= mem_dir_d;
            mem_wdata    <= mem_wdata_d;
            mem_drive    <= mem_drive_d;
        end
    end

endmodule

// File: tb/tb_atto_bus_arbiter.sv
// Directed bench for atto_bus_arbiter with WAIT_CYCLES=1.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_atto_bus_arbiter;

    localparam int unsigned WAIT = 1;
    localparam int unsigned ACK_K = 3 + WAIT;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m0_dir, m0_lock;
    logic [15:0] m0_addr;
    logic [7:0]  m0_wdata;
    logic        m1_req, m1_dir, m1_lock;
    logic [15:0] m1_addr;
    logic [7:0]  m1_wdata;
    logic        m0_grant, m1_grant, m0_ack, m1_ack;
    logic [7:0]  rdata;
    logic [15:0] mem_addr;
    logic        mem_dir;
    logic [7:0]  mem_wdata;
    logic        mem_drive;
    logic [7:0]  mem_rdata;

    int checks = 0;
    int errors = 0;
    int who;

    atto_bus_arbiter #(.WAIT_CYCLES(WAIT)) dut (
        .clock     (clock),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_dir    (m0_dir),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m1_req    (m1_req),
        .m1_dir    (m1_dir),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m0_grant  (m0_grant),
        .m1_grant  (m1_grant),
        .m0_ack    (m0_ack),
        .m1_ack    (m1_ack),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_dir   (mem_dir),
        .mem_wdata (mem_wdata),
        .mem_drive (mem_drive),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic drive_m(input int m, input logic req, input logic dir,
                           input logic [15:0] addr, input logic [7:0] wd);
        if (m == 0) begin
            m0_req = req; m0_dir = dir; m0_addr = addr; m0_wdata = wd;
        end else begin
            m1_req = req; m1_dir = dir; m1_addr = addr; m1_wdata = wd;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk1({tag, "_g0"}, m0_grant, 1'b0);
        chk1({tag, "_g1"}, m1_grant, 1'b0);
        chk1({tag, "_a0"}, m0_ack, 1'b0);
        chk1({tag, "_a1"}, m1_ack, 1'b0);
        chk16({tag, "_rdata"}, 16'(rdata), 16'h0000);
        chk16({tag, "_addr"}, mem_addr, 16'h0000);
        chk1({tag, "_dir"}, mem_dir, 1'b1);
        chk16({tag, "_wdata"}, 16'(mem_wdata), 16'h0000);
        chk1({tag, "_drive"}, mem_drive, 1'b0);
    endtask

    task automatic check_idle(input string tag);
        chk1({tag, "_g0"}, m0_grant, 1'b0);
        chk1({tag, "_g1"}, m1_grant, 1'b0);
        chk1({tag, "_a0"}, m0_ack, 1'b0);
        chk1({tag, "_a1"}, m1_ack, 1'b0);
        chk1({tag, "_dir"}, mem_dir, 1'b1);
        chk1({tag, "_drive"}, mem_drive, 1'b0);
    endtask

    // One isolated access: grant from cycle 1, ack only in cycle ACK_K
    task automatic do_access(input string tag, input int m, input logic dir,
                             input logic [15:0] addr, input logic [7:0] wd,
                             input logic [7:0] exp_rdata);
        drive_m(m, 1'b1, dir, addr, wd);
        for (int k = 1; k <= int'(ACK_K); k++) begin
            step();
            chk1({tag, "_grant_own"}, (m == 0) ? m0_grant : m1_grant, 1'b1);
            chk1({tag, "_grant_other"}, (m == 0) ? m1_grant : m0_grant, 1'b0);
            chk1({tag, "_ack_own"}, (m == 0) ? m0_ack : m1_ack, k == int'(ACK_K));
            chk1({tag, "_ack_other"}, (m == 0) ? m1_ack : m0_ack, 1'b0);
            chk1({tag, "_drive"}, mem_drive, !dir && (k < int'(ACK_K)));
            chk1({tag, "_mem_dir"}, mem_dir, dir);
            chk16({tag, "_mem_addr"}, mem_addr, addr);
            if (!dir) chk16({tag, "_mem_wdata"}, 16'(mem_wdata), 16'(wd));
        end
        chk16({tag, "_rdata"}, 16'(rdata), 16'(exp_rdata));
        drive_m(m, 1'b0, dir, addr, wd);
        step();
        check_idle({tag, "_after"});
    endtask

    // Step until an ack appears (bounded), checking mutual exclusion every cycle
    task automatic wait_ack(input string tag, output int w);
        w = -1;
        for (int n = 0; n < 12; n++) begin
            step();
            chk1({tag, "_grant_overlap"}, m0_grant & m1_grant, 1'b0);
            chk1({tag, "_ack_overlap"}, m0_ack & m1_ack, 1'b0);
            if (m0_ack || m1_ack) begin
                w = m1_ack ? 1 : 0;
                break;
            end
        end
        checks++;
        assert (w >= 0) else begin
            errors++;
            $error("FAIL %s_timeout observed %0d expected ack within 12 cycles", tag, w);
        end
    endtask

    initial begin
        reset = 1'b1;
        m0_lock = 1'b0;
        m1_lock = 1'b0;
        mem_rdata = 8'h00;
        drive_m(0, 1'b0, 1'b1, 16'h0000, 8'h00);
        drive_m(1, 1'b0, 1'b1, 16'h0000, 8'h00);

        step();
        check_reset_values("reset");
        reset = 1'b0;
        step();
        check_idle("post_reset");

        // m0 read, one wait state
        mem_rdata = 8'hA5;
        do_access("m0_read", 0, 1'b1, 16'h1234, 8'h00, 8'hA5);

        // m1 write; rdata must keep the previous read value
        mem_rdata = 8'h33;
        do_access("m1_write", 1, 1'b0, 16'h8001, 8'h5A, 8'hA5);

        // both requesting continuously: alternate starting with m0
        mem_rdata = 8'h11;
        drive_m(0, 1'b1, 1'b1, 16'h0100, 8'h00);
        drive_m(1, 1'b1, 1'b1, 16'h0200, 8'h00);
        for (int i = 0; i < 4; i++) begin
            wait_ack("rr", who);
            chk16("rr_order", 16'(who), 16'(i % 2));
        end

        // m1 locks in its DONE cycle and wins the next tie
        m1_lock = 1'b1;
        step();
        chk1("ack_pulse_width", m1_ack, 1'b0);
        m1_lock = 1'b0;
        wait_ack("lock", who);
        chk16("lock_regrant", 16'(who), 16'd1);
        wait_ack("unlock", who);
        chk16("lock_released", 16'(who), 16'd0);
        drive_m(0, 1'b0, 1'b1, 16'h0100, 8'h00);
        drive_m(1, 1'b0, 1'b1, 16'h0200, 8'h00);
        step();
        check_idle("rr_end");

        // reset during the ACCESS phase of an m0 write
        drive_m(0, 1'b1, 1'b0, 16'h4444, 8'h77);
        step();
        chk1("rst_pre_grant", m0_grant, 1'b1);
        chk1("rst_pre_drive", mem_drive, 1'b1);
        step();
        chk1("rst_access_drive", mem_drive, 1'b1);
        reset = 1'b1;
        #1;
        check_reset_values("rst_async");
        step();
        chk1("rst_no_ack", m0_ack, 1'b0);
        chk1("rst_held_grant", m0_grant, 1'b0);
        reset = 1'b0;
        step();
        chk1("rst_regrant", m0_grant, 1'b1);
        chk16("rst_regrant_addr", mem_addr, 16'h4444);
        chk16("rst_regrant_wdata", 16'(mem_wdata), 16'h0077);
        chk1("rst_regrant_drive", mem_drive, 1'b1);
        wait_ack("rst_ack", who);
        chk16("rst_ack_who", 16'(who), 16'd0);
        chk16("rst_rdata", 16'(rdata), 16'h0000);
        drive_m(0, 1'b0, 1'b0, 16'h4444, 8'h77);
        step();
        check_idle("rst_end");

        // inputs change after grant: latched copies are used
        mem_rdata = 8'h3C;
        drive_m(0, 1'b1, 1'b1, 16'h2222, 8'h00);
        step();
        chk1("latch_grant", m0_grant, 1'b1);
        chk16("latch_addr_1", mem_addr, 16'h2222);
        m0_addr = 16'hFFFF;
        m0_req = 1'b0;
        for (int k = 2; k <= int'(ACK_K); k++) begin
            step();
            chk16("latch_addr", mem_addr, 16'h2222);
            chk1("latch_ack", m0_ack, k == int'(ACK_K));
        end
        chk16("latch_rdata", 16'(rdata), 16'h003C);
        step();
        check_idle("latch_end");
        chk16("latch_addr_hold", mem_addr, 16'h2222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
